mant_request: RTL and testbench

Maintenance-request initiator: the block that drives the maintenance input `M` of the maintenance-status FSM and watches its `estado_reg` output.
- Conditions a raw front-panel button into clean single-cycle `M` pulses: synchronize, debounce, one pulse per press.
- Optionally issues automatic `M` pulses before the FSM's 200-cycle window expires.
- Raises a sticky alarm when the FSM reports error (`8'hFF`).

---
 rtl/mant_pkg.sv | 23 ++
 rtl/mant_debounce.sv | 65 ++++++
 rtl/mant_request.sv | 125 ++++++++++++
 tb/tb_mant_request.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mant_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mant_pkg
//  Brief    : Shared types and constants for the maintenance-request initiator.
//  Revision : 1.0
// ============================================================================
package mant_pkg;

  // Width of the status bus coming from the maintenance-status FSM.
  localparam int STATUS_W = 8;

  // Status code the maintenance FSM reports when it is in error.
  localparam logic [STATUS_W-1:0] ESTADO_ERROR = 8'hFF;

  // Request sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2
  } mant_state_t;

endpackage : mant_pkg
`default_nettype wire

// File: rtl/mant_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : mant_debounce
//  Brief    : 2-FF synchronizer plus stable-count debouncer for the front-panel
//             button. Emits the debounced level and a one-cycle rising strobe
//             registered together with the level change.
//  Revision : 1.0
// ============================================================================
module mant_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int                 CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule : mant_debounce
`default_nettype wire

// File: rtl/mant_request.sv
`default_nettype none
// ============================================================================
//  Module   : mant_request
//  Brief    : Maintenance-request initiator. Turns button presses (and, when
//             built with MANT_AUTO_EN, automatic window-refresh triggers) into
//             single-cycle M pulses and keeps a sticky error alarm.
//  Options  : MANT_AUTO_EN - include the automatic pulse counter/trigger.
//  Revision : 1.0
// ============================================================================
module mant_request
  import mant_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW          = 200,
  parameter int AUTO_MARGIN     = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn,
  input  logic                auto_en,
  input  logic [STATUS_W-1:0] estado_reg,
  input  logic                alarm_ack,
  output logic                M,
  output logic                alarm,
  output logic [7:0]          pulse_count
);

  mant_state_t r_state;
  mant_state_t w_next_state;
  logic        w_level;
  logic        w_rise;
  logic        w_auto_trig;
  logic        w_start;
  logic        r_m;
  logic        r_alarm;
  logic [7:0]  r_count;

  mant_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

`ifdef MANT_AUTO_EN
  localparam int                AUTO_W    = $clog2(WINDOW);
  localparam logic [AUTO_W-1:0] AUTO_MAX  = AUTO_W'(WINDOW - 1);
  localparam logic [AUTO_W-1:0] AUTO_FIRE = AUTO_W'(WINDOW - AUTO_MARGIN - 1);

  logic [AUTO_W-1:0] r_auto_cnt;

  // Cycles since the last M; zero during the pulse cycle, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_auto_cnt <= '0;
    end else if (w_next_state == S_PULSE) begin
      r_auto_cnt <= '0;
    end else if (r_auto_cnt != AUTO_MAX) begin
      r_auto_cnt <= r_auto_cnt + 1'b1;
    end
  end

  assign w_auto_trig = auto_en && (r_auto_cnt == AUTO_FIRE) && (r_state == S_IDLE);
`else
  logic w_unused_auto_en;
  assign w_unused_auto_en = auto_en;
  assign w_auto_trig      = 1'b0;
`endif

  // A coincident button edge and auto trigger collapse into one request.
  assign w_start = (w_rise || w_auto_trig) && !r_alarm;

  // Next-state logic: one pulse per accepted request, then wait out a held button.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_PULSE;
      S_PULSE: w_next_state = w_level ? S_HOLD : S_IDLE;
      S_HOLD:  if (!w_level) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered M and saturating pulse counter, both updated on entry to S_PULSE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m     <= 1'b0;
      r_count <= 8'h00;
    end else begin
      r_m <= (w_next_state == S_PULSE);
      if ((w_next_state == S_PULSE) && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  // Sticky alarm: error status sets it, ack clears it only when status is healthy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alarm <= 1'b0;
    end else if (estado_reg == ESTADO_ERROR) begin
      r_alarm <= 1'b1;
    end else if (alarm_ack) begin
      r_alarm <= 1'b0;
    end
  end

  assign M           = r_m;
  assign alarm       = r_alarm;
  assign pulse_count = r_count;

endmodule : mant_request
`default_nettype wire

// File: tb/tb_mant_request.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mant_request
//  Brief    : Scoreboard bench for mant_request. Stimulus pushes the expected
//             M edge number and pulse count; a monitor pops on every M.
//  Options  : MANT_AUTO_EN - also exercises automatic pulses.
//  Revision : 1.0
// ============================================================================
module tb_mant_request;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       auto_en = 1'b0;
  logic       alarm_ack = 1'b0;
  logic [7:0] estado_reg = 8'h00;
  logic       M;
  logic       alarm;
  logic [7:0] pulse_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int n_exp;
  bit exp_alarm;
  int q_cyc[$];
  int q_cnt[$];

  mant_request #(
    .DEBOUNCE_CYCLES (D),
    .WINDOW          (200),
    .AUTO_MARGIN     (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .auto_en     (auto_en),
    .estado_reg  (estado_reg),
    .alarm_ack   (alarm_ack),
    .M           (M),
    .alarm       (alarm),
    .pulse_count (pulse_count)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release: edge 1 is the first rising edge after release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Reference alarm: sticky, set by error status, cleared by ack on healthy status.
  always @(posedge clk or negedge rst) begin
    if (!rst)                     exp_alarm = 1'b0;
    else if (estado_reg == 8'hFF) exp_alarm = 1'b1;
    else if (alarm_ack)           exp_alarm = 1'b0;
  end

  // Monitor: compare alarm every cycle and pop the scoreboard on each M.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      vectors++;
      if (alarm !== exp_alarm) begin
        miscompares++;
        $display("FAIL alarm cyc=%0d got %0b want %0b", cyc, alarm, exp_alarm);
      end
      if (M === 1'b1) begin
        if (q_cyc.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_M cyc=%0d got M=1 want M=0", cyc);
        end else begin
          int ec;
          int en;
          ec = q_cyc.pop_front();
          en = q_cnt.pop_front();
          vectors++;
          if (cyc != ec) begin
            miscompares++;
            $display("FAIL M_time got edge %0d want edge %0d", cyc, ec);
          end
          vectors++;
          if (pulse_count !== en[7:0]) begin
            miscompares++;
            $display("FAIL M_count at edge %0d got %0d want %0d", cyc, pulse_count, en);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_expect(input int edge_no);
    n_exp = (n_exp == 255) ? 255 : n_exp + 1;
    q_cyc.push_back(edge_no);
    q_cnt.push_back(n_exp);
  endtask

  // Hold reset, check reset outputs, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    btn        = 1'b0;
    auto_en    = 1'b0;
    alarm_ack  = 1'b0;
    estado_reg = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_M", 32'(M), 32'd0);
    check("reset_alarm", 32'(alarm), 32'd0);
    check("reset_count", 32'(pulse_count), 32'd0);
    q_cyc.delete();
    q_cnt.delete();
    n_exp = 0;
    rst   = 1'b1;
  endtask

  // Button high for h edges then low for gap edges. A press stable for at least
  // D synchronized samples yields M at edge e+D+2, where e is its first sampled edge.
  task automatic press(input int h, input int gap, input bit expect_m);
    btn = 1'b1;
    if (expect_m && h >= D) push_expect(cyc + 1 + D + 2);
    repeat (h) @(negedge clk);
    btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int me;
    do_reset();

    // Clean press held 20 cycles: first M at edge 7, exactly one pulse.
    press(20, 10, 1'b1);
    check("single_press_count", 32'(pulse_count), 32'd1);

    // Short glitch must be filtered out.
    press(3, 10, 1'b1);
    check("glitch_count", 32'(pulse_count), 32'd1);

    // Randomised presses and glitches, healthy status, random acks.
    for (int i = 0; i < 40; i++) begin
      estado_reg = 8'($urandom_range(0, 254));
      alarm_ack  = 1'($urandom_range(0, 1));
`ifdef MANT_AUTO_EN
      auto_en = 1'b0;
`else
      auto_en = 1'($urandom_range(0, 1));
`endif
      press($urandom_range(1, 2 * D + 4), $urandom_range(D, 2 * D + 4), 1'b1);
    end
    alarm_ack  = 1'b0;
    auto_en    = 1'b0;
    estado_reg = 8'h00;
    check("random_count", 32'(pulse_count), 32'(n_exp));

    // Error status raises alarm, which blocks button requests.
    estado_reg = 8'hFF;
    @(negedge clk);
    estado_reg = 8'h00;
    check("alarm_set", 32'(alarm), 32'd1);
    press(20, 10, 1'b0);
    check("alarm_blocks_M", 32'(pulse_count), 32'(n_exp));
    estado_reg = 8'hFF;
    alarm_ack  = 1'b1;
    @(negedge clk);
    estado_reg = 8'h00;
    alarm_ack  = 1'b0;
    check("alarm_ack_in_error", 32'(alarm), 32'd1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("alarm_cleared", 32'(alarm), 32'd0);

    // Enough presses to saturate the pulse counter.
    for (int i = 0; i < 260; i++) press(D, D, 1'b1);
    check("count_saturated", 32'(pulse_count), 32'd255);

    // Reset asserted in the middle of a pulse that also raised the alarm.
    btn = 1'b1;
    me  = cyc + D + 3;
    push_expect(me);
    repeat (D + 2) @(negedge clk);
    check("midpulse_setup_edge", 32'(cyc), 32'(me - 1));
    estado_reg = 8'hFF;
    @(posedge clk);
    #2;
    check("midpulse_M_high", 32'(M), 32'd1);
    check("midpulse_alarm_high", 32'(alarm), 32'd1);
    rst = 1'b0;
    #1;
    check("async_reset_M", 32'(M), 32'd0);
    check("async_reset_alarm", 32'(alarm), 32'd0);
    check("async_reset_count", 32'(pulse_count), 32'd0);
    btn        = 1'b0;
    estado_reg = 8'h00;

`ifdef MANT_AUTO_EN
    // Free-running auto pulses every 180 cycles.
    do_reset();
    auto_en = 1'b1;
    push_expect(180);
    push_expect(360);
    push_expect(540);
    repeat (541) @(negedge clk);
    auto_en = 1'b0;
    check("auto_count", 32'(pulse_count), 32'd3);

    // Button rise coincides with the auto trigger: single M, counter restarts.
    do_reset();
    auto_en = 1'b1;
    repeat (173) @(negedge clk);
    push_expect(180);
    btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    push_expect(360);
    while (cyc < 361) @(negedge clk);
    auto_en = 1'b0;
    check("coincide_count", 32'(pulse_count), 32'd2);
`else
    do_reset();
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(q_cyc.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mant_request
`default_nettype wire
